// File: rtl/blackjack_pkg.sv
// Shared types for the blackjack command path: command/phase codes, button FSM states and
// the command-legality rule.
package blackjack_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_DEAL  = 2'd1,
    CMD_HIT   = 2'd2,
    CMD_STAND = 2'd3
  } cmd_t;

  typedef enum logic [1:0] {
    PH_BETTING = 2'd0,
    PH_PLAYER  = 2'd1,
    PH_DEALER  = 2'd2,
    PH_RESULT  = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUAL    = 2'd1,
    S_PEND    = 2'd2,
    S_RELEASE = 2'd3
  } btn_state_t;

  function automatic logic cmd_legal(input cmd_t c, input phase_t p);
    case (p)
      PH_BETTING, PH_RESULT: return c == CMD_DEAL;
      PH_PLAYER:             return (c == CMD_HIT) || (c == CMD_STAND);
      default:               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/button_cmd_gen_if.sv
// Command handshake between the button command generator (master) and the game FSM (slave).
interface button_cmd_gen_if;
  import blackjack_pkg::*;

  logic cmd_valid;
  logic cmd_ready;
  cmd_t cmd;
  logic cmd_rejected;
  logic cmd_timeout;

  modport master (
    output cmd_valid,
    output cmd,
    output cmd_rejected,
    output cmd_timeout,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd,
    input  cmd_rejected,
    input  cmd_timeout,
    output cmd_ready
  );

endinterface

// File: rtl/button_cmd_qual.sv
// Press edge detect, one-hot button encode and hold-stability counter; qual_pulse fires in
// the cycle the captured code has been stable for HOLD_CYCLES with the button held.
module button_cmd_qual
  import blackjack_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic left_mouse,
  input  logic deal,
  input  logic hit,
  input  logic stand,
  input  logic active,
  output logic press,
  output logic qual_pulse,
  output cmd_t qual_code
);

  localparam int unsigned CntW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(HOLD_CYCLES);

  logic            left_q;
  cmd_t            code;
  cmd_t            cap_q, cap_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    unique case ({deal, hit, stand})
      3'b100:  code = CMD_DEAL;
      3'b010:  code = CMD_HIT;
      3'b001:  code = CMD_STAND;
      default: code = CMD_NONE;
    endcase
  end

  always_comb begin
    cap_d      = cap_q;
    cnt_d      = cnt_q;
    qual_pulse = 1'b0;
    // Idle or released: start every qualification window from scratch.
    if (!active || !left_mouse) begin
      cnt_d = '0;
      cap_d = CMD_NONE;
    end else if (code == CMD_NONE) begin
      cnt_d = '0;
      cap_d = CMD_NONE;
    end else if (code != cap_q) begin
      cap_d = code;
      cnt_d = CntW'(1);
    end else begin
      qual_pulse = (cnt_q == CntMax);
      if (cnt_q != CntMax) cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q <= 1'b0;
      cap_q  <= CMD_NONE;
      cnt_q  <= '0;
    end else begin
      left_q <= left_mouse;
      cap_q  <= cap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign press     = left_mouse & ~left_q;
  assign qual_code = cap_q;

endmodule

// File: rtl/button_cmd_gen.sv
// Turns one qualified mouse press into at most one legal game command over valid/ready.
// Optional pending-command timeout is built when BUTTON_CMD_GEN_CMD_TIMEOUT_EN is defined.
module button_cmd_gen
  import blackjack_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              left_mouse,
  input  logic              deal,
  input  logic              hit,
  input  logic              stand,
  input  phase_t            game_phase,
  button_cmd_gen_if.master  cmd_bus
);

  btn_state_t state_q, state_d;
  logic       valid_q, valid_d;
  cmd_t       cmd_q, cmd_d;
  logic       rej_q, rej_d;
  logic       to_q, to_d;
  logic       press, qual_pulse, expire;
  cmd_t       qual_code;

  button_cmd_qual #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_qual (
    .clk        (clk),
    .rst        (rst),
    .left_mouse (left_mouse),
    .deal       (deal),
    .hit        (hit),
    .stand      (stand),
    .active     (state_q == S_QUAL),
    .press      (press),
    .qual_pulse (qual_pulse),
    .qual_code  (qual_code)
  );

`ifdef BUTTON_CMD_GEN_CMD_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WaitW-1:0] wait_q;

  // Counts cycles spent in S_PEND; zero on the first pending cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else if (state_q != S_PEND) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + WaitW'(1);
    end
  end

  assign expire = (state_q == S_PEND) && (wait_q == WaitW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign expire     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    cmd_d   = cmd_q;
    rej_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (press) state_d = S_QUAL;
      end
      S_QUAL: begin
        if (!left_mouse) begin
          state_d = S_IDLE;
        end else if (qual_pulse) begin
          if (cmd_legal(qual_code, game_phase)) begin
            valid_d = 1'b1;
            cmd_d   = qual_code;
            state_d = S_PEND;
          end else begin
            rej_d   = 1'b1;
            state_d = S_RELEASE;
          end
        end
      end
      S_PEND: begin
        // A transfer in the expiry cycle takes precedence over the timeout.
        if ((valid_q && cmd_bus.cmd_ready) || expire) begin
          valid_d = 1'b0;
          cmd_d   = CMD_NONE;
          to_d    = !(valid_q && cmd_bus.cmd_ready);
          state_d = left_mouse ? S_RELEASE : S_IDLE;
        end
      end
      S_RELEASE: begin
        if (!left_mouse) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      cmd_q   <= CMD_NONE;
      rej_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      rej_q   <= rej_d;
      to_q    <= to_d;
    end
  end

  assign cmd_bus.cmd_valid    = valid_q;
  assign cmd_bus.cmd          = cmd_q;
  assign cmd_bus.cmd_rejected = rej_q;
  assign cmd_bus.cmd_timeout  = to_q;

endmodule

// File: tb/tb_button_cmd_gen.sv
// Directed bench for button_cmd_gen with HOLD_CYCLES=4, TIMEOUT_CYCLES=8.
module tb_button_cmd_gen;
  import blackjack_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  logic   left_mouse, deal, hit, stand;
  phase_t game_phase;
  int     n_checks = 0;
  int     n_pass   = 0;
  int     nv, nr, nt;
  int     sv, sr, st;

  button_cmd_gen_if bus ();

  button_cmd_gen #(
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .left_mouse (left_mouse),
    .deal       (deal),
    .hit        (hit),
    .stand      (stand),
    .game_phase (game_phase),
    .cmd_bus    (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n, output int cv, output int cr, output int ct);
    cv = 0; cr = 0; ct = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      cv += int'(bus.cmd_valid);
      cr += int'(bus.cmd_rejected);
      ct += int'(bus.cmd_timeout);
    end
  endtask

  task automatic set_btn(input logic lm, input logic d, input logic h, input logic s);
    left_mouse = lm; deal = d; hit = h; stand = s;
  endtask

  // Check outputs stay quiet for 4 edges, then the command appears on the 5th.
  task automatic expect_issue(input string tag, input cmd_t c);
    run_cycles(4, nv, nr, nt);
    check_eq({tag, "_early_valid"}, nv, 0);
    tick();
    check_eq({tag, "_valid"}, int'(bus.cmd_valid), 1);
    check_eq({tag, "_cmd"}, int'(bus.cmd), int'(c));
  endtask

  initial begin
    rst = 1'b1;
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    game_phase    = PH_BETTING;
    bus.cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", int'(bus.cmd_valid), 0);
    check_eq("rst_cmd", int'(bus.cmd), int'(CMD_NONE));
    check_eq("rst_rej", int'(bus.cmd_rejected), 0);
    check_eq("rst_to", int'(bus.cmd_timeout), 0);
    rst = 1'b0;
    tick();

    // Deal in betting: code arrives the cycle after the press.
    set_btn(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    deal = 1'b1;
    expect_issue("deal", CMD_DEAL);
    tick();
    check_eq("deal_xfer_valid", int'(bus.cmd_valid), 0);
    check_eq("deal_xfer_cmd", int'(bus.cmd), int'(CMD_NONE));
    run_cycles(50, nv, nr, nt);
    check_eq("held_no_repeat", nv + nr, 0);

    // Early release in player phase.
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    game_phase = PH_PLAYER;
    set_btn(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    run_cycles(3, sv, sr, st);
    set_btn(1'b0, 1'b0, 1'b1, 1'b0);
    run_cycles(8, nv, nr, nt);
    check_eq("short_hold_valid", sv + nv, 0);
    check_eq("short_hold_rej", sr + nr, 0);

    // Illegal deal in player phase.
    set_btn(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    run_cycles(4, nv, nr, nt);
    check_eq("illegal_early_rej", nr, 0);
    tick();
    check_eq("illegal_rej", int'(bus.cmd_rejected), 1);
    check_eq("illegal_valid", int'(bus.cmd_valid), 0);
    run_cycles(10, nv, nr, nt);
    check_eq("illegal_one_pulse", nr + nv, 0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    set_btn(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_issue("stand", CMD_STAND);
    tick();
    check_eq("stand_xfer_valid", int'(bus.cmd_valid), 0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();

    // Stand pending with ready low; must hold through release and phase change.
    bus.cmd_ready = 1'b0;
    set_btn(1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    expect_issue("stall", CMD_STAND);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    game_phase = PH_DEALER;
`ifdef BUTTON_CMD_GEN_CMD_TIMEOUT_EN
    run_cycles(6, nv, nr, nt);
    check_eq("stall_hold_valid", nv, 6);
`else
    run_cycles(20, nv, nr, nt);
    check_eq("stall_hold_valid", nv, 20);
`endif
    check_eq("stall_hold_cmd", int'(bus.cmd), int'(CMD_STAND));
    check_eq("stall_no_to", nt, 0);
    bus.cmd_ready = 1'b1;
    tick();
    check_eq("stall_xfer_valid", int'(bus.cmd_valid), 0);
    check_eq("stall_xfer_cmd", int'(bus.cmd), int'(CMD_NONE));

    // Two buttons high: counting starts only after stand drops.
    game_phase = PH_PLAYER;
    set_btn(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    run_cycles(10, nv, nr, nt);
    check_eq("multi_no_cmd", nv + nr, 0);
    stand = 1'b0;
    expect_issue("multi_hit", CMD_HIT);
    tick();
    check_eq("multi_xfer_valid", int'(bus.cmd_valid), 0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();

    // Pending with ready low: timeout (if built), then async reset mid-pend.
    game_phase    = PH_BETTING;
    bus.cmd_ready = 1'b0;
`ifdef BUTTON_CMD_GEN_CMD_TIMEOUT_EN
    set_btn(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_issue("to", CMD_DEAL);
    run_cycles(7, nv, nr, nt);
    check_eq("to_valid_hold", nv, 7);
    check_eq("to_early", nt, 0);
    tick();
    check_eq("to_pulse", int'(bus.cmd_timeout), 1);
    check_eq("to_valid_drop", int'(bus.cmd_valid), 0);
    check_eq("to_cmd_none", int'(bus.cmd), int'(CMD_NONE));
    tick();
    check_eq("to_one_pulse", int'(bus.cmd_timeout), 0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
`endif
    set_btn(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    expect_issue("rstpend", CMD_DEAL);
`ifndef BUTTON_CMD_GEN_CMD_TIMEOUT_EN
    run_cycles(30, nv, nr, nt);
    check_eq("nomacro_wait_valid", nv, 30);
    check_eq("nomacro_no_to", nt, 0);
`endif
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_valid", int'(bus.cmd_valid), 0);
    check_eq("async_rst_cmd", int'(bus.cmd), int'(CMD_NONE));
    check_eq("async_rst_to", int'(bus.cmd_timeout), 0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b0;
    run_cycles(5, nv, nr, nt);
    check_eq("post_rst_quiet", nv + nr + nt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
